n_r_seq: RTL and testbench

- Read-side counterpart of the N-bit bank write-enable decoder in the signed state-vector datapath.
- Accepts a read request for one bank (`req_sel`) or for all 2^N banks (`req_all`), issues one-hot read enables and captures the addressed bank's output.
- Delivers each word on a valid/ready output stream, in bank order, with a last flag.
- Sits between the amplitude banks (synchronous read, 1-cycle latency) and the downstream gate/readout logic.

---
 rtl/n_r_seq.sv | 116 +++++++++++
 tb/tb_n_r_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/n_r_seq.sv
// n_r_seq: read-side bank sequencer for the signed state-vector datapath.
// Accepts a single-bank or all-banks read request, pulses one-hot read
// enables toward synchronous (1-cycle latency) amplitude banks, captures
// the addressed word and streams it out in bank order with a last flag.
module n_r_seq #(
    parameter int N  = 1,
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [N-1:0]          req_sel,
    input  logic                  req_all,
    output logic [(1<<N)-1:0]     r_en_out,
    input  logic [(1<<N)*DW-1:0]  r_data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [N-1:0]          out_bank,
    output logic                  out_last,
    output logic                  busy
);

    localparam int NB = 1 << N;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        OUT
    } state_t;

    state_t         state;
    logic [N-1:0]   cur;
    logic [N-1:0]   last_idx;
    logic [N-1:0]   start_idx;
    logic [N-1:0]   next_idx;
    logic [DW-1:0]  words [NB];

    // Split the concatenated bank bus into per-bank words.
    for (genvar g = 0; g < NB; g++) begin : g_words
        assign words[g] = r_data_in[g*DW +: DW];
    end

    // First bank of a new request, and the bank after the current one.
    assign start_idx = req_all ? '0 : req_sel;
    assign next_idx  = cur + 1'b1;

    function automatic logic [NB-1:0] onehot(input logic [N-1:0] idx);
        logic [NB-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Sequencer FSM: every output is a register so downstream sees clean edges.
    // The next read enable is raised on the same edge that leaves IDLE/OUT,
    // so it is high for exactly the ISSUE cycle and never during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            last_idx  <= '0;
            req_ready <= 1'b0;
            r_en_out  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bank  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        cur       <= start_idx;
                        last_idx  <= req_all ? {N{1'b1}} : req_sel;
                        r_en_out  <= onehot(start_idx);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_en_out <= '0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    // Bank output is valid only in this cycle.
                    out_data  <= words[cur];
                    out_bank  <= cur;
                    out_last  <= (cur == last_idx);
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            req_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            cur      <= next_idx;
                            r_en_out <= onehot(next_idx);
                            state    <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n_r_seq.sv
// tb_n_r_seq: directed bench for n_r_seq with N=2, DW=16. The bank model
// returns 16'h1000+i one cycle after its enable and a junk word otherwise.
module tb_n_r_seq;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int NB = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic [N-1:0]      req_sel;
    logic              req_all;
    logic [NB-1:0]     r_en_out;
    logic [NB*DW-1:0]  r_data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [N-1:0]      out_bank;
    logic              out_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    n_r_seq #(.N(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_all   (req_all),
        .r_en_out  (r_en_out),
        .r_data_in (r_data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_bank  (out_bank),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Synchronous bank model: data valid only the cycle after its enable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++)
            r_data_in[i*DW +: DW] <= r_en_out[i] ? (16'h1000 + 16'(i)) : 16'hDEAD;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic single(input logic [N-1:0] sel);
        req_valid = 1'b1;
        req_all   = 1'b0;
        req_sel   = sel;
        tick();
        req_valid = 1'b0;
        chk("s_issue_en", 32'(r_en_out), 32'(4'b0001 << sel));
        chk("s_issue_rdy", 32'(req_ready), 0);
        chk("s_issue_busy", 32'(busy), 1);
        tick();
        chk("s_cap_en", 32'(r_en_out), 0);
        chk("s_cap_vld", 32'(out_valid), 0);
        tick();
        chk("s_beat_vld", 32'(out_valid), 1);
        chk("s_beat_data", 32'(out_data), 32'h1000 + 32'(sel));
        chk("s_beat_bank", 32'(out_bank), 32'(sel));
        chk("s_beat_last", 32'(out_last), 1);
        tick();
        chk("s_done_vld", 32'(out_valid), 0);
        chk("s_done_rdy", 32'(req_ready), 1);
        chk("s_done_busy", 32'(busy), 0);
        chk("s_done_en", 32'(r_en_out), 0);
    endtask

    // All-banks read; optional 5-cycle stall at one beat; optional hammering
    // of req_valid with changing req_sel/req_all while busy.
    task automatic all_read(input int stall_bank, input bit hammer);
        req_valid = 1'b1;
        req_all   = 1'b1;
        req_sel   = 2'd3;
        tick();
        if (hammer) req_all = 1'b0;
        else        req_valid = 1'b0;
        for (int b = 0; b < NB; b++) begin
            chk("a_issue_en", 32'(r_en_out), 32'(4'b0001 << b));
            chk("a_issue_rdy", 32'(req_ready), 0);
            if (hammer) req_sel = req_sel + 2'd1;
            tick();
            chk("a_cap_en", 32'(r_en_out), 0);
            chk("a_cap_vld", 32'(out_valid), 0);
            tick();
            chk("a_beat_vld", 32'(out_valid), 1);
            chk("a_beat_data", 32'(out_data), 32'h1000 + 32'(b));
            chk("a_beat_bank", 32'(out_bank), 32'(b));
            chk("a_beat_last", 32'(out_last), (b == NB-1) ? 1 : 0);
            chk("a_beat_rdy", 32'(req_ready), 0);
            if (b == stall_bank) begin
                out_ready = 1'b0;
                repeat (5) begin
                    tick();
                    chk("st_vld", 32'(out_valid), 1);
                    chk("st_data", 32'(out_data), 32'h1000 + 32'(b));
                    chk("st_bank", 32'(out_bank), 32'(b));
                    chk("st_en", 32'(r_en_out), 0);
                end
                out_ready = 1'b1;
            end
            tick();
        end
        chk("a_done_rdy", 32'(req_ready), 1);
        chk("a_done_busy", 32'(busy), 0);
        chk("a_done_vld", 32'(out_valid), 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_sel   = '0;
        req_all   = 1'b0;
        out_ready = 1'b1;
        repeat (2) tick();
        chk("rst_vld", 32'(out_valid), 0);
        chk("rst_en", 32'(r_en_out), 0);
        chk("rst_rdy", 32'(req_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_last", 32'(out_last), 0);
        rst = 1'b0;
        chk("rel_rdy0", 32'(req_ready), 0);
        tick();
        chk("rel_rdy1", 32'(req_ready), 1);

        single(2'd2);
        single(2'd3);
        all_read(-1, 1'b0);
        all_read(1, 1'b0);
        all_read(-1, 1'b1);
        single(2'd1);

        // Asynchronous reset while a beat is stalled downstream.
        out_ready = 1'b0;
        req_valid = 1'b1;
        req_all   = 1'b0;
        req_sel   = 2'd3;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("ar_pre_vld", 32'(out_valid), 1);
        #3 rst = 1'b1;
        #1;
        chk("ar_vld", 32'(out_valid), 0);
        chk("ar_data", 32'(out_data), 0);
        chk("ar_bank", 32'(out_bank), 0);
        chk("ar_last", 32'(out_last), 0);
        chk("ar_busy", 32'(busy), 0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("ar_rdy0", 32'(req_ready), 0);
        tick();
        chk("ar_rdy1", 32'(req_ready), 1);

        // Reset during the bank-2 CAPTURE cycle of an all-banks read.
        req_valid = 1'b1;
        req_all   = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        chk("mr_issue2", 32'(r_en_out), 32'b0100);
        tick();
        chk("mr_cap_en", 32'(r_en_out), 0);
        chk("mr_cap_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("mr_vld", 32'(out_valid), 0);
        chk("mr_en", 32'(r_en_out), 0);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_rdy", 32'(req_ready), 0);
        tick();
        chk("mr_hold_vld", 32'(out_valid), 0);
        rst = 1'b0;
        tick();
        chk("mr_rdy1", 32'(req_ready), 1);
        single(2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
